// File: rtl/dmem_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
// Widths match the 16 x 8 Mem block and its 32-bit aluOut address bus.
package dmem_pkg;
   localparam int ADDR_W    = 4;
   localparam int DATA_W    = 8;
   localparam int MEM_AW    = 32;
   localparam int MEM_DEPTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      RESP
   } state_t;

   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;
endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester handshakes (req/gnt/done) for both ports plus the Mem-side bus.
// The slave modport is the arbiter's view; master is the requester/Mem side.
interface dmem_arbiter_if;
   import dmem_pkg::*;

   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic              p0_gnt;
   logic              p0_done;
   logic [DATA_W-1:0] p0_rdata;

   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_gnt;
   logic              p1_done;
   logic [DATA_W-1:0] p1_rdata;

   logic              mem_write;
   logic              mem_read;
   logic [MEM_AW-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_in;
   logic [DATA_W-1:0] mem_data_out;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      input  mem_data_out,
      output p0_gnt, p0_done, p0_rdata,
      output p1_gnt, p1_done, p1_rdata,
      output mem_write, mem_read, mem_addr, mem_data_in
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      output mem_data_out,
      input  p0_gnt, p0_done, p0_rdata,
      input  p1_gnt, p1_done, p1_rdata,
      input  mem_write, mem_read, mem_addr, mem_data_in
   );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin winner select; purely combinational, zero latency.
// A lone requester always wins; on a tie the port not served last wins.
module rr_arb2
   import dmem_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_served,
   output logic       win_id,
   output logic       win_vld
);
   always_comb begin
      win_vld = |req;
      win_id  = P0;
      case (req)
         2'b10:   win_id = P1;
         2'b11:   win_id = ~last_served;
         default: win_id = P0;
      endcase
   end
endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin access controller for two requesters sharing the 16 x 8 Mem; all outputs registered.
// Req sampled in IDLE at T -> gnt at T+1, done at T+2; one access in flight, 3 cycles per access.
module dmem_arbiter
   import dmem_pkg::*;
(
   input logic           clk,
   input logic           reset,
   dmem_arbiter_if.slave bus
);
   state_t            state, state_nxt;
   logic              last_served, last_served_nxt;
   logic              cur_id, cur_id_nxt;
   logic              cur_we, cur_we_nxt;
   logic              win_id, win_vld;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [1:0]        gnt_nxt, done_nxt;
   logic              mem_write_nxt, mem_read_nxt;
   logic [MEM_AW-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_data_in_nxt;
   logic [DATA_W-1:0] p0_rdata_nxt, p1_rdata_nxt;

   rr_arb2 u_rr_arb2 (
      .req         ({bus.p1_req, bus.p0_req}),
      .last_served (last_served),
      .win_id      (win_id),
      .win_vld     (win_vld)
   );

   assign sel_we    = (win_id == P1) ? bus.p1_we    : bus.p0_we;
   assign sel_addr  = (win_id == P1) ? bus.p1_addr  : bus.p0_addr;
   assign sel_wdata = (win_id == P1) ? bus.p1_wdata : bus.p0_wdata;

   always_comb begin
      state_nxt       = state;
      last_served_nxt = last_served;
      cur_id_nxt      = cur_id;
      cur_we_nxt      = cur_we;
      gnt_nxt         = '0;
      done_nxt        = '0;
      mem_write_nxt   = 1'b0;
      mem_read_nxt    = 1'b0;
      mem_addr_nxt    = bus.mem_addr;
      mem_data_in_nxt = bus.mem_data_in;
      p0_rdata_nxt    = bus.p0_rdata;
      p1_rdata_nxt    = bus.p1_rdata;
      unique case (state)
         IDLE: begin
            if (win_vld) begin
               state_nxt       = ACCESS;
               last_served_nxt = win_id;
               cur_id_nxt      = win_id;
               cur_we_nxt      = sel_we;
               gnt_nxt[win_id] = 1'b1;
               mem_write_nxt   = sel_we;
               mem_read_nxt    = ~sel_we;
               mem_addr_nxt    = MEM_AW'(sel_addr);
               if (sel_we) mem_data_in_nxt = sel_wdata;
            end
         end
         ACCESS: begin
            // Mem read is combinational, so its output is valid at this closing edge.
            state_nxt        = RESP;
            done_nxt[cur_id] = 1'b1;
            if (!cur_we) begin
               if (cur_id == P1) p1_rdata_nxt = bus.mem_data_out;
               else              p0_rdata_nxt = bus.mem_data_out;
            end
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         last_served     <= P1;
         cur_id          <= P0;
         cur_we          <= 1'b0;
         bus.p0_gnt      <= 1'b0;
         bus.p1_gnt      <= 1'b0;
         bus.p0_done     <= 1'b0;
         bus.p1_done     <= 1'b0;
         bus.mem_write   <= 1'b0;
         bus.mem_read    <= 1'b0;
         bus.mem_addr    <= '0;
         bus.mem_data_in <= '0;
         bus.p0_rdata    <= '0;
         bus.p1_rdata    <= '0;
      end else begin
         state           <= state_nxt;
         last_served     <= last_served_nxt;
         cur_id          <= cur_id_nxt;
         cur_we          <= cur_we_nxt;
         bus.p0_gnt      <= gnt_nxt[0];
         bus.p1_gnt      <= gnt_nxt[1];
         bus.p0_done     <= done_nxt[0];
         bus.p1_done     <= done_nxt[1];
         bus.mem_write   <= mem_write_nxt;
         bus.mem_read    <= mem_read_nxt;
         bus.mem_addr    <= mem_addr_nxt;
         bus.mem_data_in <= mem_data_in_nxt;
         bus.p0_rdata    <= p0_rdata_nxt;
         bus.p1_rdata    <= p1_rdata_nxt;
      end
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester access controller for the 16-entry x 8-bit data memory (Mem).
- Each requester uses a req/gnt/done handshake; the arbiter picks round-robin, sequences one access at a time, and drives memWrite/memRead/aluOut/dataIn.
- Read data is registered and returned per port.
- Sits between the core load/store path (port 0) and the debug/DMA loader (port 1).

Parameters:
- ADDR_W, 4, requester address width; selects one of 16 entries.
- DATA_W, 8, data width.
- MEM_AW, 32, width of the memory address bus (aluOut).

Ports:
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high; clears all state immediately
- p0_req  in  1  port 0 request, level; held until p0_done
- p0_we  in  1  port 0 op: 1=write, 0=read; stable while p0_req=1
- p0_addr  in  ADDR_W  port 0 address
- p0_wdata  in  DATA_W  port 0 write data
- p0_gnt  out  1  one-cycle pulse: port 0 access on the memory this cycle
- p0_done  out  1  one-cycle pulse: port 0 access complete
- p0_rdata  out  DATA_W  port 0 read data, valid from p0_done, held until next port 0 read
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_done, p1_rdata: same as port 0, for port 1
- mem_write  out  1  to Mem memWrite
- mem_read  out  1  to Mem memRead
- mem_addr  out  MEM_AW  to Mem aluOut; zero-extended address
- mem_data_in  out  DATA_W  to Mem dataIn
- mem_data_out  in  DATA_W  from Mem dataMemOut (combinational read)

Behaviour:
- All outputs are registered. Reset values:
  - all gnt/done/mem_write/mem_read = 0
  - mem_addr = 0, mem_data_in = 0
  - p0_rdata = p1_rdata = 0
  - state = IDLE, last_served = 1, so port 0 wins the first tie.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - req is sampled only in this state.
  - No req: stay in IDLE.
  - One req: that port wins.
  - Both req: the port != last_served wins.
  - On a win, latch the winner's id, we, addr and wdata. Next state ACCESS; last_served <= winner.
- ACCESS (exactly 1 cycle):
  - winner gnt = 1.
  - mem_addr = {28'b0, addr}.
  - Write: mem_write = 1, mem_data_in = wdata; Mem commits on the negedge inside this cycle.
  - Read: mem_read = 1.
  - At the closing posedge: if read, capture mem_data_out into the winner's rdata. Next state RESP.
- RESP (1 cycle):
  - winner done = 1; mem_* return to 0 (mem_addr and mem_data_in hold their last value).
  - Next state IDLE.
- Timing:
  - req seen high in IDLE cycle T -> gnt in T+1, done in T+2.
  - Minimum 3 cycles per access; back-to-back throughput 1 access per 3 cycles.
- Requester rule: drop req no later than the done cycle. A req still high in the following IDLE cycle is a new request.
- Writes never alter rdata; done still pulses.
- gnt and done are mutually exclusive across ports; at most one of mem_write/mem_read is high.
- Address wrap: only ADDR_W bits are used, so 4'hF is the last entry; no out-of-range case exists.
- Simultaneous requests: strict alternation under continuous contention; no port waits more than one access.
- Reset mid-operation: asynchronous reset forces IDLE and drops mem_write immediately.
  - A write whose negedge has not yet occurred is not committed.
  - The in-flight done is never issued.
- req deasserted before being sampled: ignored; no gnt.

Decomposition:
- Package dmem_pkg:
  - ADDR_W, DATA_W, MEM_AW, MEM_DEPTH = 16
  - typedef of the state enum {IDLE, ACCESS, RESP}
  - port id constants P0 = 0, P1 = 1
- Sub-module rr_arb2: combinational winner select from {p1_req, p0_req} and last_served; returns the winner id and a valid flag.
- The FSM and datapath registers stay in dmem_arbiter.

Test Plan:
1. Reset, then p0 read addr 4'h3 -> p0_gnt at T+1 with mem_read=1, mem_addr=32'h3; p0_done at T+2; p0_rdata=8'h04 (reset contents entry k = k+1).
2. p1 write addr 4'hA data 8'h5C, then p1 read 4'hA -> mem_write high exactly one cycle; then p1_rdata=8'h5C; p0_rdata unchanged.
3. After reset, p0 read 4'h2 and p1 read 4'h5 raised in the same cycle -> p0 served first (rdata 8'h03), then p1 (8'h06); gnts 3 cycles apart.
4. Both ports hold req continuously for 6 accesses -> gnt order 0,1,0,1,0,1; never two gnts in one cycle.
5. p0 write addr 4'h0 data 8'hFF with reset asserted mid-ACCESS before the negedge -> all outputs 0 at once, no p0_done; after reset, read 4'h0 returns 8'h01.
6. p0 read 4'hF -> rdata 8'h10. Then p0 write 4'hF 8'hA5 and read -> 8'hA5. req dropped before an IDLE sample -> no gnt.
